pc_target_unit: RTL and testbench

Sequential program-counter and control-flow target unit for the single-cycle CPU front end. It owns the PC register and computes the next PC each cycle: either sequential, a PC-relative branch/jump target (the former PC+immediate adder, now parameterised and shift-scaled), a register-relative jump target, or a return address popped from an internal return-address stack (RAS). It sits between instruction decode and instruction fetch. It adds stall, redirect, misalignment and RAS overflow/underflow behaviour.

---
 rtl/pc_target_unit.sv | 205 ++++++++++++++++++++
 tb/tb_pc_target_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pc_target_unit.sv
// pc_target_unit
// Program-counter register and control-flow target selection for the CPU
// front end. Each accepted cycle picks one of four next-PC sources:
// sequential, PC-relative (branch/jal), register-relative (jalr/jr), or
// the top of a small circular return-address stack.
module pc_target_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     IMM_W     = 16,
  parameter int unsigned     IMM_SHIFT = 2,
  parameter int unsigned     STEP      = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic             taken,
  input  logic [IMM_W-1:0] imm,
  input  logic [XLEN-1:0]  base,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  link,
  output logic             redirect,
  output logic             misalign,
  output logic             illegal,
  output logic             ras_underflow,
  output logic             ras_empty,
  output logic             ras_full
);

  // Operation encodings.
  localparam logic [2:0] OP_BR   = 3'd0;
  localparam logic [2:0] OP_JAL  = 3'd1;
  localparam logic [2:0] OP_JALR = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_JR   = 3'd4;

  // RAS geometry: the pointer wraps naturally because the depth is a power
  // of two; the count needs one extra bit to represent "full".
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [XLEN-1:0]  STEP_V     = XLEN'(STEP);
  // STEP is a power of two, so STEP-1 masks exactly the alignment bits
  // (and is zero when STEP=1, which disables the alignment check).
  localparam logic [XLEN-1:0]  ALIGN_MASK = XLEN'(STEP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(RAS_DEPTH);

  // Architectural state.
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;    // next free slot; top entry sits at ras_ptr-1
  logic [CNT_W-1:0] ras_cnt;
  logic             redirect_q;
  logic             misalign_q;
  logic             illegal_q;
  logic             underflow_q;

  // Datapath values.
  logic [XLEN-1:0]  imm_sext;
  logic [XLEN-1:0]  pc_rel_target;
  logic [XLEN-1:0]  reg_rel_target;
  logic [PTR_W-1:0] top_idx;
  logic [XLEN-1:0]  ras_top;

  // Decode results.
  logic             accepted;
  logic             take;
  logic             push_req;
  logic             pop_req;
  logic             reserved_op;
  logic             ret_empty;
  logic [XLEN-1:0]  target;
  logic             bad_align;
  logic             do_redirect;
  logic             do_push;
  logic             do_pop;
  logic [XLEN-1:0]  next_pc;

  // Outputs derived purely from registered state.
  assign pc            = pc_q;
  assign link          = pc_q + STEP_V;
  assign redirect      = redirect_q;
  assign misalign      = misalign_q;
  assign illegal       = illegal_q;
  assign ras_underflow = underflow_q;
  assign ras_empty     = (ras_cnt == '0);
  assign ras_full      = (ras_cnt == CNT_MAX);

  // Target adders; all arithmetic is modulo 2^XLEN with the carry dropped.
  assign imm_sext       = XLEN'($signed(imm));
  assign pc_rel_target  = pc_q + (imm_sext << IMM_SHIFT);
  assign reg_rel_target = base + imm_sext;
  assign top_idx        = ras_ptr - PTR_W'(1);
  assign ras_top        = ras_mem[top_idx];

  // Decode the presented op into a candidate target and RAS request.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    accepted    = op_valid & ~stall;
    take        = 1'b0;
    push_req    = 1'b0;
    pop_req     = 1'b0;
    reserved_op = 1'b0;
    ret_empty   = 1'b0;
    target      = pc_rel_target;
    if (accepted) begin
      case (op)
        OP_BR: begin
          take   = taken;
          target = pc_rel_target;
        end
        OP_JAL: begin
          take     = 1'b1;
          push_req = 1'b1;
          target   = pc_rel_target;
        end
        OP_JALR: begin
          take     = 1'b1;
          push_req = 1'b1;
          target   = reg_rel_target;
        end
        OP_RET: begin
          target = ras_top;
          if (ras_empty) begin
            ret_empty = 1'b1;
          end else begin
            take    = 1'b1;
            pop_req = 1'b1;
          end
        end
        OP_JR: begin
          take   = 1'b1;
          target = reg_rel_target;
        end
        default: reserved_op = 1'b1;
      endcase
    end
  end

  // Reject misaligned targets: no redirect and no RAS side effect.
  always_comb begin
    bad_align   = take && ((target & ALIGN_MASK) != '0);
    do_redirect = take & ~bad_align;
    do_push     = push_req & do_redirect;
    do_pop      = pop_req & do_redirect;
    if (bad_align) begin
      next_pc = pc_q;
    end else if (do_redirect) begin
      next_pc = target;
    end else begin
      next_pc = link;
    end
  end

  // PC register and one-cycle status flags; flags clear on a stalled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      redirect_q  <= 1'b0;
      misalign_q  <= 1'b0;
      illegal_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (!stall) begin
        pc_q <= next_pc;
      end
      redirect_q  <= do_redirect;
      misalign_q  <= bad_align;
      illegal_q   <= reserved_op;
      underflow_q <= ret_empty;
    end
  end

  // RAS pointer and occupancy; a push on a full stack overwrites the oldest
  // entry, so the count saturates at RAS_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (do_push) begin
      ras_ptr <= ras_ptr + PTR_W'(1);
      if (ras_cnt != CNT_MAX) begin
        ras_cnt <= ras_cnt + CNT_W'(1);
      end
    end else if (do_pop) begin
      ras_ptr <= top_idx;
      ras_cnt <= ras_cnt - CNT_W'(1);
    end
  end

  // RAS storage, written with the link address on each push.
  always_ff @(posedge clk) begin
    // NOTE: entries are not reset; validity is tracked by ras_cnt alone, so
    // the storage stays a plain register file without a reset network.
    if (do_push) begin
      ras_mem[ras_ptr] <= link;
    end
  end

endmodule

// File: tb/tb_pc_target_unit.sv
// Testbench for pc_target_unit: a directed vector table applied one cycle
// per entry, followed by hand-written RAS overflow and mid-cycle reset
// sequences.
module tb_pc_target_unit;

  localparam logic [2:0] BR = 3'd0, JAL = 3'd1, JALR = 3'd2, RET = 3'd3, JR = 3'd4;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        op_valid;
  logic [2:0]  op;
  logic        taken;
  logic [15:0] imm;
  logic [31:0] base;
  logic [31:0] pc;
  logic [31:0] link;
  logic        redirect, misalign, illegal, ras_underflow, ras_empty, ras_full;

  int checks   = 0;
  int failures = 0;

  pc_target_unit #(
    .XLEN(32), .IMM_W(16), .IMM_SHIFT(2), .STEP(4),
    .RESET_PC(32'h0), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .op_valid(op_valid), .op(op),
    .taken(taken), .imm(imm), .base(base), .pc(pc), .link(link),
    .redirect(redirect), .misalign(misalign), .illegal(illegal),
    .ras_underflow(ras_underflow), .ras_empty(ras_empty), .ras_full(ras_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        op_valid;
    logic [2:0]  op;
    logic        taken;
    logic [15:0] imm;
    logic [31:0] base;
    logic [31:0] exp_pc;
    logic        exp_red;
    logic        exp_mis;
    logic        exp_ill;
    logic        exp_uf;
    logic        exp_empty;
    logic        exp_full;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic v, input logic [2:0] o, input logic t,
                     input logic [15:0] i, input logic [31:0] b, input logic [31:0] epc,
                     input logic er, input logic em, input logic ei, input logic eu,
                     input logic ee, input logic ef);
    vec_t x;
    x.stall = s; x.op_valid = v; x.op = o; x.taken = t; x.imm = i; x.base = b;
    x.exp_pc = epc; x.exp_red = er; x.exp_mis = em; x.exp_ill = ei; x.exp_uf = eu;
    x.exp_empty = ee; x.exp_full = ef;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic s, input logic v, input logic [2:0] o,
                       input logic [15:0] i, input logic [31:0] b);
    stall = s; op_valid = v; op = o; taken = 1'b0; imm = i; base = b;
  endtask

  // Advance one edge and sample 1 ns later, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, BR, 16'h0, 32'h0);

    //   stall vld op    tk imm      base          exp_pc        red mis ill uf emp full
    add(0, 0, BR,   0, 16'h0000, 32'h0,        32'h0000_0004, 0, 0, 0, 0, 1, 0);
    add(0, 0, BR,   0, 16'h0000, 32'h0,        32'h0000_0008, 0, 0, 0, 0, 1, 0);
    add(0, 0, BR,   0, 16'h0000, 32'h0,        32'h0000_000C, 0, 0, 0, 0, 1, 0);
    add(0, 1, JR,   0, 16'h0000, 32'h100,      32'h0000_0100, 1, 0, 0, 0, 1, 0);
    add(0, 1, BR,   1, 16'hFFFE, 32'h0,        32'h0000_00F8, 1, 0, 0, 0, 1, 0);
    add(0, 1, JR,   0, 16'h0000, 32'h100,      32'h0000_0100, 1, 0, 0, 0, 1, 0);
    add(0, 1, BR,   0, 16'hFFFE, 32'h0,        32'h0000_0104, 0, 0, 0, 0, 1, 0);
    add(0, 1, JR,   0, 16'h0000, 32'h40,       32'h0000_0040, 1, 0, 0, 0, 1, 0);
    add(0, 1, JAL,  0, 16'h0010, 32'h0,        32'h0000_0080, 1, 0, 0, 0, 0, 0);
    add(0, 1, RET,  0, 16'h0000, 32'h0,        32'h0000_0044, 1, 0, 0, 0, 1, 0);
    add(0, 1, RET,  0, 16'h0000, 32'h0,        32'h0000_0048, 0, 0, 0, 1, 1, 0);
    add(0, 0, BR,   0, 16'h0000, 32'h0,        32'h0000_004C, 0, 0, 0, 0, 1, 0);
    add(0, 1, 3'd5, 0, 16'h0000, 32'h0,        32'h0000_0050, 0, 0, 1, 0, 1, 0);
    add(1, 1, 3'd7, 0, 16'h0000, 32'h0,        32'h0000_0050, 0, 0, 0, 0, 1, 0);
    add(1, 1, JAL,  0, 16'h0004, 32'h0,        32'h0000_0050, 0, 0, 0, 0, 1, 0);
    add(0, 1, JALR, 0, 16'h0000, 32'h201,      32'h0000_0050, 0, 1, 0, 0, 1, 0);
    add(0, 1, JAL,  0, 16'h0001, 32'h0,        32'h0000_0054, 1, 0, 0, 0, 0, 0);
    add(0, 1, JALR, 0, 16'h0001, 32'h102,      32'h0000_0054, 0, 1, 0, 0, 0, 0);
    add(0, 1, JALR, 0, 16'hFFFC, 32'h300,      32'h0000_02FC, 1, 0, 0, 0, 0, 0);
    add(0, 1, RET,  0, 16'h0000, 32'h0,        32'h0000_0058, 1, 0, 0, 0, 0, 0);
    add(0, 1, RET,  0, 16'h0000, 32'h0,        32'h0000_0054, 1, 0, 0, 0, 1, 0);
    add(0, 1, JR,   0, 16'h0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0, 0, 1, 0);
    add(0, 0, BR,   0, 16'h0000, 32'h0,        32'h0000_0000, 0, 0, 0, 0, 1, 0);

    // Reset state.
    #3;
    check("reset pc", pc, 32'h0);
    check("reset redirect", {31'h0, redirect}, 32'h0);
    check("reset pulses", {29'h0, misalign, illegal, ras_underflow}, 32'h0);
    check("reset empty/full", {30'h0, ras_empty, ras_full}, 32'h2);
    check("reset link", link, 32'h4);
    rst_n = 1'b1;

    // Vector table, one entry per cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      stall = vecs[i].stall; op_valid = vecs[i].op_valid; op = vecs[i].op;
      taken = vecs[i].taken; imm = vecs[i].imm; base = vecs[i].base;
      step();
      check($sformatf("v%0d pc", i), pc, vecs[i].exp_pc);
      check($sformatf("v%0d link", i), link, vecs[i].exp_pc + 32'd4);
      check($sformatf("v%0d redirect", i), {31'h0, redirect}, {31'h0, vecs[i].exp_red});
      check($sformatf("v%0d misalign", i), {31'h0, misalign}, {31'h0, vecs[i].exp_mis});
      check($sformatf("v%0d illegal", i), {31'h0, illegal}, {31'h0, vecs[i].exp_ill});
      check($sformatf("v%0d underflow", i), {31'h0, ras_underflow}, {31'h0, vecs[i].exp_uf});
      check($sformatf("v%0d empty", i), {31'h0, ras_empty}, {31'h0, vecs[i].exp_empty});
      check($sformatf("v%0d full", i), {31'h0, ras_full}, {31'h0, vecs[i].exp_full});
    end

    // Five JALs from pc=0 (links 0x4..0x14); the oldest link is overwritten.
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, JAL, 16'h0001, 32'h0);
      step();
      check($sformatf("jal%0d pc", k), pc, 32'(4 * (k + 1)));
      check($sformatf("jal%0d full", k), {31'h0, ras_full}, (k >= 3) ? 32'h1 : 32'h0);
    end
    // Four RETs return 0x14, 0x10, 0xC, 0x8 in LIFO order.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, RET, 16'h0, 32'h0);
      step();
      check($sformatf("ret%0d pc", k), pc, 32'(32'h14 - 4 * k));
      check($sformatf("ret%0d full", k), {31'h0, ras_full}, 32'h0);
      check($sformatf("ret%0d empty", k), {31'h0, ras_empty}, (k == 3) ? 32'h1 : 32'h0);
    end
    // Fifth RET underflows and falls through sequentially.
    drive(1'b0, 1'b1, RET, 16'h0, 32'h0);
    step();
    check("ret4 pc", pc, 32'hC);
    check("ret4 underflow", {31'h0, ras_underflow}, 32'h1);
    check("ret4 redirect", {31'h0, redirect}, 32'h0);

    // Build RAS count=2, then assert reset mid-cycle while a JAL is presented.
    drive(1'b0, 1'b1, JAL, 16'h0001, 32'h0);
    step();
    step();
    check("pre-reset pc", pc, 32'h14);
    check("pre-reset redirect", {31'h0, redirect}, 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset pc", pc, 32'h0);
    check("async reset redirect", {31'h0, redirect}, 32'h0);
    check("async reset empty/full", {30'h0, ras_empty, ras_full}, 32'h2);
    step();
    check("reset held pc", pc, 32'h0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, BR, 16'h0, 32'h0);
    step();
    check("post-reset pc", pc, 32'h4);
    // The RAS must be empty after reset: RET underflows.
    drive(1'b0, 1'b1, RET, 16'h0, 32'h0);
    step();
    check("post-reset ret pc", pc, 32'h8);
    check("post-reset ret underflow", {31'h0, ras_underflow}, 32'h1);
    drive(1'b0, 1'b0, BR, 16'h0, 32'h0);
    step();
    check("underflow clears", {31'h0, ras_underflow}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
